// File: rtl/axon_spike_decoder_pkg.sv
// axon_decoder_pkg: width helpers and read FSM state encoding for the axon spike decoder
package axon_decoder_pkg;
  function automatic int axon_w(input int num_axons);
    return $clog2(num_axons);
  endfunction
  function automatic int cnt_w(input int fifo_depth);
    return $clog2(fifo_depth) + 1;
  endfunction
  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RELEASE
  } rd_state_e;
endpackage

// File: rtl/axon_spike_decoder_if.sv
// axon_spike_decoder_if: packet ingress and controller fetch signals of the axon spike decoder
interface axon_spike_decoder_if
  import axon_decoder_pkg::*;
#(
  parameter int NUM_AXONS  = 256,
  parameter int FIFO_DEPTH = 16
) ();
  localparam int AXON_W = axon_w(NUM_AXONS);
  localparam int CNT_W  = cnt_w(FIFO_DEPTH);
  logic [AXON_W-1:0] packet_in;
  logic              packet_valid;
  logic              packet_ready;
  logic              decoder_empty;
  logic              read_spike;
  logic [AXON_W-1:0] axon_number_out;
  logic              axon_number_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  modport master (
    output packet_in, packet_valid, read_spike,
    input  packet_ready, decoder_empty, axon_number_out, axon_number_valid, fifo_count, overflow
  );
  modport slave (
    input  packet_in, packet_valid, read_spike,
    output packet_ready, decoder_empty, axon_number_out, axon_number_valid, fifo_count, overflow
  );
endinterface

// File: rtl/axon_spike_decoder_fifo.sv
// spike_sync_fifo: synchronous FIFO with wrapping pointers and registered occupancy count
module spike_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  assign full    = count_q == CNT_W'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end
  // pointer and count registers, emptied by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/axon_spike_decoder.sv
// axon_spike_decoder: buffers axon spike packets and serves them one per fetch episode (AXON_DEDUP_EN adds queued-axon dedup)
module axon_spike_decoder
  import axon_decoder_pkg::*;
#(
  parameter int NUM_AXONS  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  axon_spike_decoder_if.slave bus
);
  localparam int AXON_W = axon_w(NUM_AXONS);
  localparam int CNT_W  = cnt_w(FIFO_DEPTH);
  rd_state_e         state_q, state_d;
  logic [AXON_W-1:0] axon_q, axon_d;
  logic              overflow_q, overflow_d;
  logic [AXON_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full, empty, accept, store, pop_en;
  assign bus.packet_ready      = !full;
  assign bus.decoder_empty     = empty;
  assign bus.fifo_count        = count;
  assign bus.axon_number_out   = axon_q;
  assign bus.axon_number_valid = state_q == SERVE;
  assign bus.overflow          = overflow_q;
  assign accept = bus.packet_valid && !full;
  assign pop_en = state_q == IDLE && bus.read_spike && !empty;
  spike_sync_fifo #(
    .W    (AXON_W),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (store),
    .pop  (pop_en),
    .din  (bus.packet_in),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );
`ifdef AXON_DEDUP_EN
  logic [NUM_AXONS-1:0] queued_q, queued_d;
  // a packet already queued is swallowed unless that same axon leaves the queue this cycle
  assign store = accept && (!queued_q[bus.packet_in] || (pop_en && head == bus.packet_in));
  // bitmap of axons currently held in the FIFO
  always_comb begin
    queued_d = queued_q;
    if (pop_en) queued_d[head] = 1'b0;
    if (accept) queued_d[bus.packet_in] = 1'b1;
  end
  // bitmap register, cleared with the FIFO
  always_ff @(posedge clk) begin
    if (!rst) queued_q <= '0;
    else queued_q <= queued_d;
  end
`else
  assign store = accept;
`endif
  // read FSM: one pop per read_spike episode, valid strobe in SERVE, wait for release
  always_comb begin
    state_d    = state_q == IDLE  ? (pop_en ? SERVE : IDLE)
               : state_q == SERVE ? RELEASE
               : (bus.read_spike ? RELEASE : IDLE);
    axon_d     = pop_en ? head : axon_q;
    overflow_d = overflow_q || (bus.packet_valid && full);
  end
  // state, served axon and sticky overflow registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      axon_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      axon_q     <= axon_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
